// File: rtl/gf180mcu_fd_sc_mcu7t5v0__segdrv_ctl8.sv
// gf180mcu_fd_sc_mcu7t5v0__segdrv_ctl8: stepped enable ramp for eight invz legs so di/dt rises one leg at a time.
module gf180mcu_fd_sc_mcu7t5v0__segdrv_ctl8 #(
    parameter int STEP_CYC = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       I,
    output logic [7:0] SEG_EN,
    output logic [7:0] SEG_I,
    output logic       FULL,
    output logic       BUSY,
    inout  wire        VDD,
    inout  wire        VSS
);
    typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DN} state_t;
    localparam logic [3:0] RLD = 4'(STEP_CYC - 1);
    state_t state, state_n;
    logic [3:0] cnt, cnt_n, tmr, tmr_n;
    logic i_q;
    wire unused = VDD ^ VSS;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= OFF;
            cnt   <= 4'd0;
            tmr   <= 4'd0;
            i_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            tmr   <= tmr_n;
            i_q   <= I;
        end
    end
    // A reversal only reloads the timer, so the count never jumps by more than one leg.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tmr_n   = tmr;
        case (state)
            OFF: if (EN) begin
                cnt_n   = 4'd1;
                tmr_n   = RLD;
                state_n = RAMP_UP;
            end
            RAMP_UP: if (!EN) begin
                tmr_n   = RLD;
                state_n = RAMP_DN;
            end else if (tmr != 4'd0) begin
                tmr_n = tmr - 4'd1;
            end else if (cnt == 4'd7) begin
                cnt_n   = 4'd8;
                state_n = ON;
            end else begin
                cnt_n = cnt + 4'd1;
                tmr_n = RLD;
            end
            ON: if (!EN) begin
                cnt_n   = 4'd7;
                tmr_n   = RLD;
                state_n = RAMP_DN;
            end
            RAMP_DN: if (EN) begin
                tmr_n   = RLD;
                state_n = RAMP_UP;
            end else if (tmr != 4'd0) begin
                tmr_n = tmr - 4'd1;
            end else if (cnt == 4'd1) begin
                cnt_n   = 4'd0;
                state_n = OFF;
            end else begin
                cnt_n = cnt - 4'd1;
                tmr_n = RLD;
            end
            default: state_n = OFF;
        endcase
    end
    assign SEG_EN = 8'hFF >> (4'd8 - cnt);
    assign SEG_I  = {8{i_q}};
    assign FULL   = state == ON;
    assign BUSY   = state == RAMP_UP || state == RAMP_DN;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__segdrv_ctl8.sv
// tb_gf180mcu_fd_sc_mcu7t5v0__segdrv_ctl8: directed ramp, reversal, reset and data-path checks for three STEP_CYC settings.
module tb_gf180mcu_fd_sc_mcu7t5v0__segdrv_ctl8;
    typedef struct {
        logic [7:0] se;
        logic [7:0] si;
        logic       f;
        logic       b;
        string      tag;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic i = 1'b0;
    wire vdd, vss;
    assign vdd = 1'b1;
    assign vss = 1'b0;
    logic [7:0] se1, se2, se3, si1, si2, si3;
    logic f1, f2, f3, b1, b2, b3;
    int sel = 2;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    always #5 clk = ~clk;
    gf180mcu_fd_sc_mcu7t5v0__segdrv_ctl8 #(.STEP_CYC(1)) d1 (.CLK(clk), .RST(rst), .EN(en), .I(i),
        .SEG_EN(se1), .SEG_I(si1), .FULL(f1), .BUSY(b1), .VDD(vdd), .VSS(vss));
    gf180mcu_fd_sc_mcu7t5v0__segdrv_ctl8 #(.STEP_CYC(2)) d2 (.CLK(clk), .RST(rst), .EN(en), .I(i),
        .SEG_EN(se2), .SEG_I(si2), .FULL(f2), .BUSY(b2), .VDD(vdd), .VSS(vss));
    gf180mcu_fd_sc_mcu7t5v0__segdrv_ctl8 #(.STEP_CYC(3)) d3 (.CLK(clk), .RST(rst), .EN(en), .I(i),
        .SEG_EN(se3), .SEG_I(si3), .FULL(f3), .BUSY(b3), .VDD(vdd), .VSS(vss));
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step(input logic r, input logic e, input logic d, input int cnt,
                        input logic f, input logic b, input string tag);
        exp_t x;
        logic [7:0] se, si;
        logic ff, bb;
        rst = r;
        en  = e;
        i   = d;
        x.se  = 8'((1 << cnt) - 1);
        x.si  = r ? 8'h00 : {8{d}};
        x.f   = f;
        x.b   = b;
        x.tag = tag;
        q.push_back(x);
        @(posedge clk);
        #1;
        x  = q.pop_front();
        se = sel == 1 ? se1 : sel == 3 ? se3 : se2;
        si = sel == 1 ? si1 : sel == 3 ? si3 : si2;
        ff = sel == 1 ? f1 : sel == 3 ? f3 : f2;
        bb = sel == 1 ? b1 : sel == 3 ? b3 : b2;
        chk({x.tag, ".seg_en"}, se, x.se);
        chk({x.tag, ".seg_i"}, si, x.si);
        chk({x.tag, ".full"}, {7'd0, ff}, {7'd0, x.f});
        chk({x.tag, ".busy"}, {7'd0, bb}, {7'd0, x.b});
    endtask
    initial begin
        @(posedge clk);
        #1;
        sel = 2;
        for (int k = 0; k < 3; k++) step(1, 1, 1, 0, 0, 0, "rst");
        for (int k = 1; k <= 15; k++) step(0, 1, k[0], 1 + (k - 1) / 2, k == 15, k != 15, "up2");
        for (int k = 0; k < 2; k++) step(0, 1, k[0], 8, 1, 0, "on2");
        for (int k = 1; k <= 15; k++) step(0, 0, k[0], 7 - (k - 1) / 2, 0, k != 15, "dn2");
        step(0, 0, 0, 0, 0, 0, "off2");
        step(0, 1, 1, 1, 0, 1, "pulse");
        step(0, 0, 0, 1, 0, 1, "pulse_rev");
        step(0, 0, 1, 1, 0, 1, "pulse_hold");
        step(0, 0, 0, 0, 0, 0, "pulse_off");
        sel = 3;
        step(1, 0, 0, 0, 0, 0, "rst3");
        for (int k = 1; k <= 10; k++) step(0, 1, k[0], 1 + (k - 1) / 3, 0, 1, "up3");
        for (int k = 0; k < 3; k++) step(0, 0, k[0], 4, 0, 1, "rev_hold");
        step(0, 0, 1, 3, 0, 1, "rev_dn");
        for (int k = 0; k < 3; k++) step(0, 1, k[0], 3, 0, 1, "rev2_hold");
        step(0, 1, 0, 4, 0, 1, "rev_up");
        sel = 1;
        step(1, 1, 1, 0, 0, 0, "rst1");
        for (int k = 1; k <= 5; k++) step(0, 1, k[0], k, 0, 1, "up1");
        step(1, 1, 1, 0, 0, 0, "mid_rst");
        for (int k = 1; k <= 8; k++) step(0, 1, k[0], k, k == 8, k != 8, "up1_again");
        step(0, 1, 1, 8, 1, 0, "on1");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
